// File: rtl/fixed_point_subtractor_serial.sv
// rtl/fixed_point_subtractor_serial.sv - bit-serial sign-magnitude fixed-point subtractor (c = a - b)
module fixed_point_subtractor_serial #(
    parameter int Q = 8,
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         ovf
);

    localparam int M  = N - 1;
    localparam int CW = (M > 1) ? $clog2(M) : 1;

    if (N < 3 || Q > M) begin : g_param_check
        $fatal(1, "fixed_point_subtractor_serial: need N >= 3 and Q <= N-1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [M-1:0]  r_x;
    logic [M-1:0]  r_y;
    logic [M-1:0]  r_res;
    logic          r_carry;
    logic          r_add;
    logic          r_sign;
    logic [CW-1:0] r_cnt;

    logic [M-1:0]  w_mag_a;
    logic [M-1:0]  w_mag_b;
    logic          w_sign_a;
    logic          w_add;
    logic          w_swap;
    logic          w_x;
    logic          w_y;
    logic          w_bit;
    logic          w_cout;
    logic          w_last;
    logic [M-1:0]  w_sum;
    logic          w_ovf;
    logic [M-1:0]  w_mag;
    logic [N-1:0]  w_c;

    assign w_mag_a  = a[M-1:0];
    assign w_mag_b  = b[M-1:0];
    assign w_sign_a = a[N-1];
    assign w_add    = a[N-1] ^ b[N-1];
    assign w_swap   = (w_mag_a < w_mag_b);

    // x always holds the larger magnitude in SUB mode, so the borrow chain never wraps
    assign w_x    = r_x[0];
    assign w_y    = r_y[0];
    assign w_bit  = w_x ^ w_y ^ r_carry;
    assign w_cout = r_add ? ((w_x & w_y) | (w_x & r_carry) | (w_y & r_carry))
                          : ((~w_x & w_y) | (~(w_x ^ w_y) & r_carry));
    assign w_last = (r_cnt == CW'(M - 1));

    assign w_sum = {w_bit, r_res[M-1:1]};
    assign w_ovf = r_add & w_cout;
    assign w_mag = w_ovf ? {M{1'b1}} : w_sum;
    assign w_c   = {r_sign & (w_mag != '0), w_mag};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_res     <= '0;
            r_carry   <= 1'b0;
            r_add     <= 1'b0;
            r_sign    <= 1'b0;
            r_cnt     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            c         <= '0;
            ovf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (!w_add && w_swap) begin
                            r_x <= w_mag_b;
                            r_y <= w_mag_a;
                        end else begin
                            r_x <= w_mag_a;
                            r_y <= w_mag_b;
                        end
                        r_add    <= w_add;
                        r_sign   <= w_add ? w_sign_a : (w_sign_a ^ w_swap);
                        r_res    <= '0;
                        r_carry  <= 1'b0;
                        r_cnt    <= '0;
                        in_ready <= 1'b0;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_x     <= r_x >> 1;
                    r_y     <= r_y >> 1;
                    r_res   <= w_sum;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        c         <= w_c;
                        ovf       <= w_ovf;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
